// File: rtl/parity_frame_tx.sv
// parity_frame_tx
// Transmit-side serializer for the serial parity checker. A parallel word
// and a parity mode are accepted over ready/valid. The word is then sent one
// bit per cycle, LSB first, followed by a parity bit that makes the total
// count of ones even (mode 0) or odd (mode 1). A downstream hold freezes
// shifting. After each frame an optional number of forced idle cycles
// elapses before the next word is accepted.

module parity_frame_tx #(
  parameter int DATA_W   = 7,
  parameter int IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ser_hold,
  output logic              ser_data,
  output logic              ser_valid,
  output logic              ser_mode,
  output logic              frame_done,
  output logic              busy,
  output logic [7:0]        frame_count
);

  // bit_idx must be able to reach DATA_W, which is the index of the parity bit.
  localparam int IDX_W = (DATA_W > 0) ? $clog2(DATA_W + 1) : 1;
  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            state_reg;
  logic [DATA_W:0]   shreg_reg;
  logic [IDX_W-1:0]  bit_idx_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              ser_mode_reg;
  logic              frame_done_reg;
  logic [7:0]        frame_count_reg;

  // The parity chain is seeded with the mode bit. With a 0 seed the chain
  // yields even parity; with a 1 seed it yields odd parity over the frame.
  logic [DATA_W:0]   par_chain;
  logic              par_bit;

  assign par_chain[0] = in_mode;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ in_data[gi];
    end
  endgenerate

  assign par_bit = par_chain[DATA_W];

  logic accept;
  logic last_xfer;

  // The handshake and serial strobes are combinational, so a stall or a new
  // offer is seen in the same cycle it is presented.
  assign in_ready  = (state_reg == ST_IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign ser_valid = (state_reg == ST_SHIFT) && !ser_hold;
  assign ser_data  = (state_reg == ST_SHIFT) ? shreg_reg[0] : 1'b0;
  assign busy      = (state_reg != ST_IDLE);
  assign last_xfer = ser_valid && (bit_idx_reg == IDX_W'(DATA_W));

  assign ser_mode    = ser_mode_reg;
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;

  // Frame sequencer: load on accept, shift on each transfer, then idle gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      shreg_reg       <= '0;
      bit_idx_reg     <= '0;
      gap_cnt_reg     <= '0;
      ser_mode_reg    <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= 8'd0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            shreg_reg    <= {par_bit, in_data};
            ser_mode_reg <= in_mode;
            bit_idx_reg  <= '0;
            state_reg    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ser_valid) begin
            shreg_reg   <= {1'b0, shreg_reg[DATA_W:1]};
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (last_xfer) begin
              bit_idx_reg     <= '0;
              frame_done_reg  <= 1'b1;
              frame_count_reg <= frame_count_reg + 8'd1;
              gap_cnt_reg     <= '0;
              if (IDLE_GAP > 0) begin
                state_reg <= ST_GAP;
              end else begin
                state_reg <= ST_IDLE;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == GAP_W'(IDLE_GAP - 1)) begin
            gap_cnt_reg <= '0;
            state_reg   <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
